// File: rtl/dotn_acc.sv
// dotn_acc -- pipelined signed dot-product unit with multi-chunk accumulation.
//
// Each valid beat ("chunk") carries LANES signed element pairs. The chunk's
// lane products are reduced by a registered pairwise adder tree, and the tree
// sum is accumulated across chunks framed by ifirst/ilast. One chunk is
// accepted per cycle with no backpressure. The latency from the edge that
// samples the ilast chunk to ovalid is log2(LANES)+3 cycles, counting that
// sampling edge as the first.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   vec0    packed signed operand A, lane i at [(i+1)*IWIDTH-1 : i*IWIDTH]
//   vec1    packed signed operand B, same packing
//   ivalid  chunk valid this cycle
//   ifirst  chunk starts a new dot product (qualified by ivalid)
//   ilast   chunk ends the dot product (qualified by ivalid)
//   result  signed accumulated dot product, held between ovalid pulses
//   ovalid  one-cycle pulse, result is valid
//   err     one-cycle pulse on a framing violation (or saturation at emit)
//
// Optional feature macro: DOTN_SATURATE_EN
//   When this macro is defined, every accumulator update clamps to the OWIDTH
//   signed range. A sticky saturation flag, cleared by a first chunk, is ORed
//   into err when the product is emitted. When it is undefined, the
//   accumulator wraps in two's complement.

module dotn_acc #(
  parameter int LANES  = 8,
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*IWIDTH-1:0]   vec0,
  input  logic [LANES*IWIDTH-1:0]   vec1,
  input  logic                      ivalid,
  input  logic                      ifirst,
  input  logic                      ilast,
  output logic signed [OWIDTH-1:0]  result,
  output logic                      ovalid,
  output logic                      err
);

  localparam int LOG2  = $clog2(LANES);
  localparam int PW    = 2 * IWIDTH;       // product width
  localparam int SW    = PW + LOG2;        // tree output width
  localparam int DEPTH = LOG2 + 2;         // S0, S1 and one tree level per stage

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } flags_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  // ---------------------------------------------------------------------------
  // S0: operand capture and flag pipeline
  // ---------------------------------------------------------------------------
  logic [LANES*IWIDTH-1:0] a_r, b_r;
  flags_t                  fl_sr [DEPTH];

  // NOTE: the lane registers are plain flops rather than a RAM, so they are reset
  // along with everything else. This keeps the tree free of X after reset.
  // NOTE: clocked state uses non-blocking assignments so that every stage
  // samples the value its upstream neighbour held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
    end else if (ivalid) begin
      a_r <= vec0;
      b_r <= vec1;
    end
  end

  // valid/first/last ride alongside the data. Element DEPTH-1 lines up with
  // the tree output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fl_sr[i] <= '0;
    end else begin
      fl_sr[0] <= '{valid: ivalid, first: ifirst, last: ilast};
      for (int i = 1; i < DEPTH; i++) fl_sr[i] <= fl_sr[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // S1: lane products
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [IWIDTH-1:0] a_lane, b_lane;
    logic signed [PW-1:0]     prod;

    assign a_lane = a_r[i*IWIDTH +: IWIDTH];
    assign b_lane = b_r[i*IWIDTH +: IWIDTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) prod <= '0;
      else     prod <= a_lane * b_lane;   // both operands signed: full signed product
    end
  end

  // ---------------------------------------------------------------------------
  // S2..S(1+LOG2): pairwise adder tree, one bit wider per level
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < LOG2; l++) begin : g_lvl
    localparam int N = LANES >> (l + 1);
    localparam int W = PW + l + 1;

    for (genvar k = 0; k < N; k++) begin : g_node
      logic [W-2:0] in_a, in_b;
      logic [W-1:0] node;

      if (l == 0) begin : g_leaf
        assign in_a = g_lane[2*k].prod;
        assign in_b = g_lane[2*k+1].prod;
      end else begin : g_inner
        assign in_a = g_lvl[l-1].g_node[2*k].node;
        assign in_b = g_lvl[l-1].g_node[2*k+1].node;
      end

      // Manual sign extension keeps the growth explicit at each level.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) node <= '0;
        else     node <= {in_a[W-2], in_a} + {in_b[W-2], in_b};
      end
    end
  end

  logic signed [SW-1:0]     tree_sum;
  logic signed [OWIDTH-1:0] sum_ext;
  flags_t                   sa_fl;

  assign tree_sum = g_lvl[LOG2-1].g_node[0].node;
  assign sum_ext  = OWIDTH'(tree_sum);
  assign sa_fl    = fl_sr[DEPTH-1];

  // ---------------------------------------------------------------------------
  // SA: framing FSM and accumulator
  // ---------------------------------------------------------------------------
  state_t                   state, state_nx;
  logic signed [OWIDTH-1:0] acc, acc_nx;
  logic signed [OWIDTH-1:0] result_nx;
  logic                     ovalid_nx, err_nx;
  logic                     start, ferr;
  logic signed [OWIDTH-1:0] base, upd;
`ifdef DOTN_SATURATE_EN
  localparam logic signed [OWIDTH-1:0] ACC_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic signed [OWIDTH-1:0] ACC_MIN = {1'b1, {(OWIDTH-1){1'b0}}};
  logic              sat, sat_nx;
  logic [OWIDTH:0]   wide;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      result <= '0;
      ovalid <= 1'b0;
      err    <= 1'b0;
`ifdef DOTN_SATURATE_EN
      sat    <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      result <= result_nx;
      ovalid <= ovalid_nx;
      err    <= err_nx;
`ifdef DOTN_SATURATE_EN
      sat    <= sat_nx;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    result_nx = result;
    ovalid_nx = 1'b0;
    err_nx    = 1'b0;
    start     = 1'b0;
    ferr      = 1'b0;
    base      = '0;
    upd       = '0;
`ifdef DOTN_SATURATE_EN
    sat_nx    = sat;
    wide      = '0;
`endif

    if (sa_fl.valid) begin
      // A chunk seen in IDLE always starts a product. In ACCUM, a first chunk
      // drops the partial and restarts. The framing error is the mismatch
      // between the first flag and the state.
      start = (state == IDLE) || sa_fl.first;
      ferr  = (state == IDLE) ? !sa_fl.first : sa_fl.first;
      base  = start ? '0 : acc;

`ifdef DOTN_SATURATE_EN
      wide = {base[OWIDTH-1], base} + {sum_ext[OWIDTH-1], sum_ext};
      if (wide[OWIDTH] != wide[OWIDTH-1]) upd = wide[OWIDTH] ? ACC_MIN : ACC_MAX;
      else                                upd = wide[OWIDTH-1:0];
      sat_nx = (start ? 1'b0 : sat) | (wide[OWIDTH] != wide[OWIDTH-1]);
`else
      upd = base + sum_ext;
`endif

      acc_nx = upd;
      err_nx = ferr;

      if (sa_fl.last) begin
        result_nx = upd;
        ovalid_nx = 1'b1;
        state_nx  = IDLE;
`ifdef DOTN_SATURATE_EN
        err_nx    = ferr | sat_nx;
`endif
      end else begin
        state_nx  = ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_dotn_acc.sv
// Self-checking bench for dotn_acc.
// The main instance uses LANES=8, IWIDTH=8, OWIDTH=32. A second instance with
// OWIDTH=20 shares the same stimulus and is used for the overflow scenario.
// An ovalid event is stamped with the cycle counter. A chunk driven while the
// counter reads c is sampled by the next edge, so its ovalid is expected at
// stamp c+6.

module tb_dotn_acc;

  localparam int LAT = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [63:0]        vec0, vec1;
  logic               ivalid, ifirst, ilast;
  logic signed [31:0] result;
  logic               ovalid, err;
  logic signed [19:0] result_w;
  logic               ovalid_w, err_w;

  dotn_acc #(.LANES(8), .IWIDTH(8), .OWIDTH(32)) dut (
    .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1),
    .ivalid(ivalid), .ifirst(ifirst), .ilast(ilast),
    .result(result), .ovalid(ovalid), .err(err)
  );

  dotn_acc #(.LANES(8), .IWIDTH(8), .OWIDTH(20)) dut_w (
    .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1),
    .ivalid(ivalid), .ifirst(ifirst), .ilast(ilast),
    .result(result_w), .ovalid(ovalid_w), .err(err_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic signed [31:0] res;
    logic               err;
  } ev_t;

  int  cyc = 0;
  ev_t q32[$];
  ev_t qw[$];
  int  eo32 = 0;     // err pulses without ovalid, main instance
  int  eow  = 0;     // same, narrow instance
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ovalid) q32.push_back('{cyc, result, err});
    else if (err) eo32++;
    if (ovalid_w) qw.push_back('{cyc, {{12{result_w[19]}}, result_w}, err_w});
    else if (err_w) eow++;
  end

  function automatic logic [63:0] fill(input logic [7:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic f, input logic l, output int c);
    @(negedge clk);
    vec0 = a; vec1 = b; ivalid = 1'b1; ifirst = f; ilast = l;
    c = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    ivalid = 1'b0; ifirst = 1'b0; ilast = 1'b0;
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic clear_log();
    q32.delete(); qw.delete(); eo32 = 0; eow = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; vec0 = '0; vec1 = '0; ivalid = 1'b0; ifirst = 1'b0; ilast = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (result !== 32'sd0) begin n_bad++; $display("FAIL reset/result: got %0d want 0", result); end
    n_cmp++; if (ovalid !== 1'b0) begin n_bad++; $display("FAIL reset/ovalid: got %b want 0", ovalid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset/err: got %b want 0", err); end
    n_cmp++; if (result_w !== 20'sd0) begin n_bad++; $display("FAIL reset/result_w: got %0d want 0", result_w); end
    n_cmp++; if (ovalid_w !== 1'b0 || err_w !== 1'b0) begin n_bad++; $display("FAIL reset/flags_w: got %b%b want 00", ovalid_w, err_w); end
    #10 rst = 1'b0;
    settle();
    clear_log();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    int  c;
    ev_t e;
    clear_log();
    drive(fill(8'd1), fill(8'd1), 1'b1, 1'b1, c);
    idle(); settle();
    n_cmp++; if (q32.size() !== 1) begin n_bad++; $display("FAIL single/count: got %0d want 1", q32.size()); end
    if (q32.size() > 0) e = q32[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.cyc !== c + LAT) begin n_bad++; $display("FAIL single/latency: got %0d want %0d", e.cyc, c + LAT); end
    n_cmp++; if (e.res !== 32'sd8) begin n_bad++; $display("FAIL single/result: got %0d want 8", e.res); end
    n_cmp++; if (e.err !== 1'b0) begin n_bad++; $display("FAIL single/err: got %b want 0", e.err); end
  endtask

  // ---------------------------------------------------------------------------
  // Two single-chunk products on consecutive cycles: extremes, then mixed signs.
  task automatic test_back_to_back();
    int          c0, c1;
    logic [63:0] alt;
    ev_t         e0, e1;
    clear_log();
    for (int i = 0; i < 8; i++) alt[i*8 +: 8] = (i % 2 == 0) ? 8'h7f : 8'h80;
    drive(fill(8'h80), fill(8'h80), 1'b1, 1'b1, c0);
    drive(alt,         fill(8'h80), 1'b1, 1'b1, c1);
    idle(); settle();
    n_cmp++; if (q32.size() !== 2) begin n_bad++; $display("FAIL b2b/count: got %0d want 2", q32.size()); end
    if (q32.size() > 0) e0 = q32[0]; else e0 = '{-1, 'x, 1'bx};
    if (q32.size() > 1) e1 = q32[1]; else e1 = '{-1, 'x, 1'bx};
    n_cmp++; if (e0.res !== 32'sd131072) begin n_bad++; $display("FAIL b2b/min_sq: got %0d want 131072", e0.res); end
    n_cmp++; if (e1.res !== 32'sd512) begin n_bad++; $display("FAIL b2b/alt: got %0d want 512", e1.res); end
    n_cmp++; if (e1.cyc !== c1 + LAT || e0.cyc !== c0 + LAT) begin
      n_bad++; $display("FAIL b2b/timing: got %0d,%0d want %0d,%0d", e0.cyc, e1.cyc, c0 + LAT, c1 + LAT);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Three chunks of 2*3 (48 each): back-to-back, then with two idle cycles
  // between chunks.
  task automatic test_multi_chunk();
    int  c, cs, t_b2b, t_gap;
    ev_t e;
    clear_log();
    drive(fill(8'd2), fill(8'd3), 1'b1, 1'b0, cs);
    drive(fill(8'd2), fill(8'd3), 1'b0, 1'b0, c);
    drive(fill(8'd2), fill(8'd3), 1'b0, 1'b1, c);
    idle(); settle();
    n_cmp++; if (q32.size() !== 1) begin n_bad++; $display("FAIL multi/count: got %0d want 1", q32.size()); end
    if (q32.size() > 0) e = q32[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.res !== 32'sd144 || e.err !== 1'b0) begin n_bad++; $display("FAIL multi/result: got %0d err %b want 144 err 0", e.res, e.err); end
    n_cmp++; if (e.cyc !== cs + 2 + LAT) begin n_bad++; $display("FAIL multi/latency: got %0d want %0d", e.cyc, cs + 2 + LAT); end
    t_b2b = e.cyc - cs;

    clear_log();
    drive(fill(8'd2), fill(8'd3), 1'b1, 1'b0, cs);
    idle(); idle();
    drive(fill(8'd2), fill(8'd3), 1'b0, 1'b0, c);
    idle(); idle();
    drive(fill(8'd2), fill(8'd3), 1'b0, 1'b1, c);
    idle(); settle();
    n_cmp++; if (q32.size() !== 1) begin n_bad++; $display("FAIL gap/count: got %0d want 1", q32.size()); end
    if (q32.size() > 0) e = q32[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.res !== 32'sd144) begin n_bad++; $display("FAIL gap/result: got %0d want 144", e.res); end
    t_gap = e.cyc - cs;
    n_cmp++; if (t_gap - t_b2b !== 4) begin n_bad++; $display("FAIL gap/delay: got %0d want 4", t_gap - t_b2b); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_framing();
    int  c;
    ev_t e;
    // Chunk without ifirst in IDLE: err and ovalid on the same cycle.
    clear_log();
    drive(fill(8'd1), fill(8'd1), 1'b0, 1'b1, c);
    idle(); settle();
    n_cmp++; if (q32.size() !== 1) begin n_bad++; $display("FAIL nofirst/count: got %0d want 1", q32.size()); end
    if (q32.size() > 0) e = q32[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.err !== 1'b1 || e.res !== 32'sd8) begin n_bad++; $display("FAIL nofirst/out: got %0d err %b want 8 err 1", e.res, e.err); end
    n_cmp++; if (e.cyc !== c + LAT) begin n_bad++; $display("FAIL nofirst/latency: got %0d want %0d", e.cyc, c + LAT); end

    // ifirst mid-accumulation: the 96 partial is dropped, the result is 8+8.
    clear_log();
    drive(fill(8'd2), fill(8'd3), 1'b1, 1'b0, c);
    drive(fill(8'd2), fill(8'd3), 1'b0, 1'b0, c);
    drive(fill(8'd1), fill(8'd1), 1'b1, 1'b0, c);
    drive(fill(8'd1), fill(8'd1), 1'b0, 1'b1, c);
    idle(); settle();
    n_cmp++; if (eo32 !== 1) begin n_bad++; $display("FAIL refirst/err_pulses: got %0d want 1", eo32); end
    n_cmp++; if (q32.size() !== 1) begin n_bad++; $display("FAIL refirst/count: got %0d want 1", q32.size()); end
    if (q32.size() > 0) e = q32[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.res !== 32'sd16 || e.err !== 1'b0) begin n_bad++; $display("FAIL refirst/out: got %0d err %b want 16 err 0", e.res, e.err); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int  c;
    ev_t e;
    clear_log();
    drive(fill(8'd1), fill(8'd1), 1'b1, 1'b0, c);
    drive(fill(8'd1), fill(8'd1), 1'b0, 1'b1, c);
    idle();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (result !== 32'sd0 || ovalid !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL midrst/async: got %0d %b %b want 0 0 0", result, ovalid, err);
    end
    #9 rst = 1'b0;
    settle();
    n_cmp++; if (q32.size() !== 0 || eo32 !== 0) begin n_bad++; $display("FAIL midrst/flush: got %0d ovalid %0d err want 0 0", q32.size(), eo32); end
    n_cmp++; if (result !== 32'sd0) begin n_bad++; $display("FAIL midrst/hold: got %0d want 0", result); end
    clear_log();
    drive(fill(8'd1), fill(8'd1), 1'b1, 1'b1, c);
    idle(); settle();
    if (q32.size() > 0) e = q32[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.res !== 32'sd8 || e.cyc !== c + LAT) begin n_bad++; $display("FAIL midrst/after: got %0d at %0d want 8 at %0d", e.res, e.cyc, c + LAT); end
  endtask

  // ---------------------------------------------------------------------------
  // Five chunks of -128*-128 (131072 each, 655360 total) overflow 20 bits.
  task automatic test_overflow();
    int  c;
    ev_t e;
`ifdef DOTN_SATURATE_EN
    logic signed [31:0] w_exp = 32'sd524287;
    logic               w_err = 1'b1;
`else
    logic signed [31:0] w_exp = -32'sd393216;
    logic               w_err = 1'b0;
`endif
    clear_log();
    for (int i = 0; i < 5; i++) drive(fill(8'h80), fill(8'h80), i == 0, i == 4, c);
    idle(); settle();
    if (q32.size() > 0) e = q32[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.res !== 32'sd655360) begin n_bad++; $display("FAIL ovf/wide: got %0d want 655360", e.res); end
    n_cmp++; if (qw.size() !== 1) begin n_bad++; $display("FAIL ovf/count_w: got %0d want 1", qw.size()); end
    if (qw.size() > 0) e = qw[0]; else e = '{-1, 'x, 1'bx};
    n_cmp++; if (e.res !== w_exp) begin n_bad++; $display("FAIL ovf/result_w: got %0d want %0d", e.res, w_exp); end
    n_cmp++; if (e.err !== w_err || eow !== 0) begin n_bad++; $display("FAIL ovf/err_w: got %b (%0d bare) want %b (0 bare)", e.err, eow, w_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_multi_chunk();
    test_framing();
    test_reset_mid();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
